// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Holds the program counter, issues
//               word reads over a req/ack handshake, latches the returned
//               word into the instruction register and holds it for decode.
//               IR[7:0] feeds the downstream sign extender as imm8.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    output logic [7:0]  imm8,
    output logic        fault
);

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic        fault_q, fault_d;

    // Memory request decodes the state register directly; the address is
    // the PC, which only changes on leaving HOLD, so it is stable in FETCH.
    assign mem_req  = (state_q == FETCH);
    assign mem_addr = pc_q;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign imm8     = ir_q[7:0];
    assign fault    = fault_q;

    // Next-state logic: handshake capture in FETCH, consume/redirect in HOLD.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        fault_d    = fault_q;
        case (state_q)
            START: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (mem_ack) begin
                    ir_d       = mem_rdata;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (!stall) begin
                    ir_valid_d = 1'b0;
                    if (branch_taken && (branch_target[1:0] != 2'b00)) begin
                        // Misaligned redirect: park until reset, PC untouched.
                        fault_d = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d    = branch_taken ? branch_target : (ir_pc_q + PC_STEP);
                        state_d = FETCH;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = START;
            end
        endcase
    end

    // State register with synchronous reset; ir is deliberately not cleared
    // when ir_valid drops so imm8 stays settled for the sign extender.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= START;
            pc_q       <= RESET_PC;
            ir_q       <= 32'h0;
            ir_pc_q    <= 32'h0;
            ir_valid_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            fault_q    <= fault_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed, table-driven bench for instr_fetch. Each vector is
//               one clock of inputs plus the outputs expected after that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic [7:0]  imm8;
    logic        fault;

    // Second instance exercising PC wrap from the top of the address space.
    logic        w_reset;
    logic        w_mem_req;
    logic [31:0] w_mem_addr;
    logic        w_mem_ack;
    logic [31:0] w_mem_rdata;
    logic        w_stall;
    logic        w_branch_taken;
    logic [31:0] w_branch_target;
    logic [31:0] w_ir;
    logic [31:0] w_ir_pc;
    logic        w_ir_valid;
    logic [7:0]  w_imm8;
    logic        w_fault;

    int checks = 0;
    int errors = 0;

    instr_fetch dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .imm8(imm8), .fault(fault)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut_wrap (
        .clk(clk), .reset(w_reset), .mem_req(w_mem_req), .mem_addr(w_mem_addr),
        .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata), .stall(w_stall),
        .branch_taken(w_branch_taken), .branch_target(w_branch_target),
        .ir(w_ir), .ir_pc(w_ir_pc), .ir_valid(w_ir_valid), .imm8(w_imm8), .fault(w_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        stl;
        logic        br;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_ir;
        logic [31:0] e_irpc;
        logic        e_valid;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic ack, input logic [31:0] rdata,
                       input logic stl, input logic br, input logic [31:0] tgt,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic [31:0] e_ir, input logic [31:0] e_irpc,
                       input logic e_valid, input logic e_fault);
        vec_t v;
        v.rst = rst; v.ack = ack; v.rdata = rdata; v.stl = stl; v.br = br; v.tgt = tgt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_ir = e_ir; v.e_irpc = e_irpc;
        v.e_valid = e_valid; v.e_fault = e_fault;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        reset = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;
        w_reset = 1'b1; w_mem_ack = 1'b0; w_mem_rdata = 32'h0; w_stall = 1'b0;
        w_branch_taken = 1'b0; w_branch_target = 32'h0;

        //   rst ack rdata          stl br tgt          req addr          ir             ir_pc         v  f
        // Reset, then always-ack memory returning 0xE2.
        add(1, 0, 32'h0,          0, 0, 32'h0,        0, 32'h0,        32'h0,         32'h0,        0, 0);
        add(0, 1, 32'h0000_00E2,  0, 0, 32'h0,        1, 32'h0,        32'h0,         32'h0,        0, 0);
        add(0, 1, 32'h0000_00E2,  0, 0, 32'h0,        0, 32'h0,        32'h0000_00E2, 32'h0,        1, 0);
        // Sequential fetch; ack in HOLD is ignored.
        add(0, 1, 32'h0000_0123,  0, 0, 32'h0,        1, 32'h4,        32'h0000_00E2, 32'h0,        0, 0);
        add(0, 1, 32'h1111_1104,  0, 0, 32'h0,        0, 32'h4,        32'h1111_1104, 32'h4,        1, 0);
        add(0, 0, 32'h0,          0, 0, 32'h0,        1, 32'h8,        32'h1111_1104, 32'h4,        0, 0);
        add(0, 1, 32'h2222_2208,  0, 0, 32'h0,        0, 32'h8,        32'h2222_2208, 32'h8,        1, 0);
        // Late ack (3 idle cycles); stall/branch ignored in FETCH.
        add(0, 0, 32'h0,          0, 0, 32'h0,        1, 32'hC,        32'h2222_2208, 32'h8,        0, 0);
        add(0, 0, 32'hDEAD_BEEF,  1, 1, 32'h200,      1, 32'hC,        32'h2222_2208, 32'h8,        0, 0);
        add(0, 0, 32'hDEAD_BEEF,  1, 1, 32'h200,      1, 32'hC,        32'h2222_2208, 32'h8,        0, 0);
        add(0, 0, 32'hDEAD_BEEF,  0, 0, 32'h0,        1, 32'hC,        32'h2222_2208, 32'h8,        0, 0);
        add(0, 1, 32'h3333_33C7,  0, 0, 32'h0,        0, 32'hC,        32'h3333_33C7, 32'hC,        1, 0);
        // Four stalled cycles: everything frozen, branch and ack ignored.
        for (int k = 0; k < 4; k++)
            add(0, 1, 32'hAAAA_AAAA, 1, 1, 32'h200,   0, 32'hC,        32'h3333_33C7, 32'hC,        1, 0);
        // Aligned branch to 0x100.
        add(0, 0, 32'h0,          0, 1, 32'h100,      1, 32'h100,      32'h3333_33C7, 32'hC,        0, 0);
        add(0, 1, 32'h4444_4455,  0, 0, 32'h0,        0, 32'h100,      32'h4444_4455, 32'h100,      1, 0);
        // Misaligned branch: fault, HALT, nothing more issued.
        add(0, 0, 32'h0,          0, 1, 32'h102,      0, 32'h100,      32'h4444_4455, 32'h100,      0, 1);
        add(0, 1, 32'h5555_5555,  0, 1, 32'h200,      0, 32'h100,      32'h4444_4455, 32'h100,      0, 1);
        add(0, 1, 32'h5555_5555,  0, 0, 32'h0,        0, 32'h100,      32'h4444_4455, 32'h100,      0, 1);
        add(0, 0, 32'h0,          1, 0, 32'h0,        0, 32'h100,      32'h4444_4455, 32'h100,      0, 1);
        // Reset clears the fault and restarts.
        add(1, 0, 32'h0,          0, 0, 32'h0,        0, 32'h0,        32'h0,         32'h0,        0, 0);
        add(0, 0, 32'h0,          0, 0, 32'h0,        1, 32'h0,        32'h0,         32'h0,        0, 0);
        // Reset during FETCH with ack in the same cycle: ack lost.
        add(1, 1, 32'h5555_5566,  0, 0, 32'h0,        0, 32'h0,        32'h0,         32'h0,        0, 0);
        add(0, 1, 32'h5555_5566,  0, 0, 32'h0,        1, 32'h0,        32'h0,         32'h0,        0, 0);
        add(0, 0, 32'h0,          0, 0, 32'h0,        1, 32'h0,        32'h0,         32'h0,        0, 0);
        add(0, 1, 32'h0000_0066,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0066, 32'h0,        1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset         = vecs[i].rst;
            mem_ack       = vecs[i].ack;
            mem_rdata     = vecs[i].rdata;
            stall         = vecs[i].stl;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            @(posedge clk);
            #1;
            chk("mem_req",  i, {31'b0, mem_req},  {31'b0, vecs[i].e_req});
            chk("mem_addr", i, mem_addr,          vecs[i].e_addr);
            chk("ir",       i, ir,                vecs[i].e_ir);
            chk("ir_pc",    i, ir_pc,             vecs[i].e_irpc);
            chk("ir_valid", i, {31'b0, ir_valid}, {31'b0, vecs[i].e_valid});
            chk("imm8",     i, {24'b0, imm8},     {24'b0, vecs[i].e_ir[7:0]});
            chk("fault",    i, {31'b0, fault},    {31'b0, vecs[i].e_fault});
        end

        // PC wrap: RESET_PC = 0xFFFF_FFFC, second fetch goes to 0.
        @(negedge clk); w_reset = 1'b0;
        chk("wrap_reset_addr", 0, w_mem_addr, 32'hFFFF_FFFC);
        chk("wrap_reset_req",  0, {31'b0, w_mem_req}, 32'h0);
        @(posedge clk); #1;
        chk("wrap_first_req",  1, {31'b0, w_mem_req}, 32'h1);
        chk("wrap_first_addr", 1, w_mem_addr, 32'hFFFF_FFFC);
        @(negedge clk); w_mem_ack = 1'b1; w_mem_rdata = 32'h0000_007F;
        @(posedge clk); #1;
        chk("wrap_ir_pc",      2, w_ir_pc, 32'hFFFF_FFFC);
        chk("wrap_imm8",       2, {24'b0, w_imm8}, 32'h7F);
        chk("wrap_ir_valid",   2, {31'b0, w_ir_valid}, 32'h1);
        @(negedge clk); w_mem_ack = 1'b0;
        @(posedge clk); #1;
        chk("wrap_second_req",  3, {31'b0, w_mem_req}, 32'h1);
        chk("wrap_second_addr", 3, w_mem_addr, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
